// File: rtl/axis.sv
// -----------------------------------------------------------------------------
// axis -- single-clock AXI-Stream register stage with a one-entry skid buffer.
//
// Both handshake directions are registered. s_tready comes only from the skid
// flag, and m_tvalid/m_tdata come only from the output register. As a result,
// no combinational path runs from m_tready to s_tready. The stage sustains one
// beat per cycle under any backpressure pattern. Words leave in acceptance
// order, with no loss and no duplication.
//
// Parameters
//   WIDTH      tdata width in bits (>= 1)
//   CNT_WIDTH  width of the monitor counters (>= 2); counters wrap
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   s_tdata     upstream data
//   s_tvalid    upstream valid
//   s_tready    ready to upstream (low while rst is high or skid is full)
//   m_tdata     downstream data
//   m_tvalid    downstream valid
//   m_tready    downstream ready
//   xfer_cnt    number of output beats (m_tvalid && m_tready)
//   stall_cnt   number of cycles with m_tvalid && !m_tready
//   last_data   tdata of the most recent output beat
//   last_valid  high once any output beat has occurred since reset
// -----------------------------------------------------------------------------
module axis #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [WIDTH-1:0]     m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [CNT_WIDTH-1:0] xfer_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [WIDTH-1:0]     last_data,
    output logic                 last_valid
);

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic in_beat;
    logic out_beat;
    logic stall;
    logic load_out;

    // The skid entry can only fill while the output register is full.
    // Therefore "skid empty" is exactly "room for one more word".
    assign s_tready = !skid_valid && !rst;
    assign m_tvalid = out_valid;
    assign m_tdata  = out_data;

    assign in_beat  = s_tvalid && s_tready;
    assign out_beat = out_valid && m_tready;
    assign stall    = out_valid && !m_tready;
    // The output register may take a new word when it is empty or draining.
    assign load_out = !out_valid || m_tready;

    // NOTE: sequential state is always written with non-blocking assignments,
    // so every register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                // The skid word is older than anything on the input.
                // s_tready is low here, so no input beat can collide with it.
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_beat) begin
                out_data  <= s_tdata;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_beat) begin
            // The output is held by backpressure, so park the word.
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid_data is pure datapath qualified by skid_valid, so it needs
    // no reset; leaving it out keeps the reset net off the data flops.
    always_ff @(posedge clk) begin
        if (!load_out && in_beat) begin
            skid_data <= s_tdata;
        end
    end

    // Monitor counters and last-beat capture; the counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt   <= '0;
            stall_cnt  <= '0;
            last_data  <= '0;
            last_valid <= 1'b0;
        end else begin
            if (out_beat) begin
                xfer_cnt   <= xfer_cnt + 1'b1;
                last_data  <= out_data;
                last_valid <= 1'b1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis.sv
// -----------------------------------------------------------------------------
// tb_axis -- self-checking bench for axis.
//
// Two instances share the same handshake stimulus:
//   u_dut    WIDTH=16, CNT_WIDTH=32
//   u_small  WIDTH=2,  CNT_WIDTH=2   (narrow data ramp and counter wrap)
//
// The reference model treats the stage as a FIFO of capacity two:
//   s_tready = fewer than two words held
//   m_tvalid = at least one word held
//   m_tdata  = oldest word held
// -----------------------------------------------------------------------------
module tb_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;

    logic        s_tready, m_tvalid, last_valid;
    logic [15:0] m_tdata, last_data;
    logic [31:0] xfer_cnt, stall_cnt;

    logic        s_tready_s, m_tvalid_s, last_valid_s;
    logic [1:0]  m_tdata_s, last_data_s, xfer_cnt_s, stall_cnt_s;

    int passed = 0;
    int total  = 0;

    // Reference model state.
    logic [15:0] q[$];
    int unsigned mx = 0;
    int unsigned ms = 0;
    logic [15:0] mlast = '0;
    logic        mlast_valid = 1'b0;

    axis #(.WIDTH(16), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt),
        .last_data(last_data), .last_valid(last_valid)
    );

    axis #(.WIDTH(2), .CNT_WIDTH(2)) u_small (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata[1:0]), .s_tvalid(s_tvalid), .s_tready(s_tready_s),
        .m_tdata(m_tdata_s), .m_tvalid(m_tvalid_s), .m_tready(m_tready),
        .xfer_cnt(xfer_cnt_s), .stall_cnt(stall_cnt_s),
        .last_data(last_data_s), .last_valid(last_valid_s)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and advance the model. On return, time is
    // 1 ns after the rising edge, which is a safe point to sample outputs.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        bit ib, ob, st;
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        ib = v && (q.size() < 2) && !rst;
        ob = (q.size() > 0) && r;
        st = (q.size() > 0) && !r;
        @(posedge clk);
        #1;
        if (ob) begin
            mlast       = q.pop_front();
            mlast_valid = 1'b1;
            mx++;
        end
        if (st) ms++;
        if (ib) q.push_back(d);
    endtask

    task automatic model_clear();
        q.delete();
        mx = 0;
        ms = 0;
        mlast = '0;
        mlast_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({m_tvalid, s_tready, m_tdata} !== 18'h0)
            $display("FAIL reset_out: got v=%b rdy=%b d=%h, want 0", m_tvalid, s_tready, m_tdata);
        else passed++;
        total++;
        if ({xfer_cnt, stall_cnt, last_data, last_valid} !== 81'h0)
            $display("FAIL reset_mon: got x=%0d s=%0d ld=%h lv=%b, want 0",
                     xfer_cnt, stall_cnt, last_data, last_valid);
        else passed++;
        total++;
        if ({m_tvalid_s, s_tready_s, xfer_cnt_s, stall_cnt_s, last_valid_s} !== 7'h0)
            $display("FAIL reset_small: got v=%b rdy=%b x=%0d s=%0d lv=%b, want 0",
                     m_tvalid_s, s_tready_s, xfer_cnt_s, stall_cnt_s, last_valid_s);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_continuous();
        logic [15:0] val;
        for (int i = 0; i < 20; i++) begin
            val = 16'(i);
            step(1'b1, val, 1'b1);
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== val)
                $display("FAIL cont_data[%0d]: got v=%b d=%h, want v=1 d=%h", i, m_tvalid, m_tdata, val);
            else passed++;
            total++;
            if (m_tdata_s !== val[1:0])
                $display("FAIL cont_ramp2[%0d]: got %0d, want %0d", i, m_tdata_s, val[1:0]);
            else passed++;
            total++;
            if (xfer_cnt !== 32'(i) || stall_cnt !== 32'd0)
                $display("FAIL cont_cnt[%0d]: got x=%0d s=%0d, want x=%0d s=0", i, xfer_cnt, stall_cnt, i);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] nxt;
        nxt = 16'd100;
        for (int i = 0; i < 24; i++) begin
            // The source advances only when its word was accepted.
            if (q.size() < 2) begin
                step(1'b1, nxt, (i % 4) != 3);
                nxt++;
            end else begin
                step(1'b1, nxt, (i % 4) != 3);
            end
            total++;
            if (m_tvalid !== (q.size() > 0) || s_tready !== (q.size() < 2))
                $display("FAIL bp_hs[%0d]: got v=%b rdy=%b, want v=%b rdy=%b",
                         i, m_tvalid, s_tready, q.size() > 0, q.size() < 2);
            else passed++;
            total++;
            if (q.size() > 0 && m_tdata !== q[0])
                $display("FAIL bp_data[%0d]: got %h, want %h", i, m_tdata, q[0]);
            else passed++;
            total++;
            if (stall_cnt !== ms || last_data !== mlast)
                $display("FAIL bp_mon[%0d]: got s=%0d ld=%h, want s=%0d ld=%h",
                         i, stall_cnt, last_data, ms, mlast);
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [15:0] rel_d  [3] = '{16'd4, 16'd4, 16'd5};
        logic [15:0] rel_ld [3] = '{16'd2, 16'd3, 16'd4};
        repeat (3) step(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, (k == 0) ? 16'd2 : ((k == 1) ? 16'd3 : 16'd4), 1'b0);
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== 16'd2)
                $display("FAIL hold_out[%0d]: got v=%b d=%h, want v=1 d=0002", k, m_tvalid, m_tdata);
            else passed++;
            if (k >= 1) begin
                total++;
                if (s_tready !== 1'b0)
                    $display("FAIL hold_rdy[%0d]: got %b, want 0", k, s_tready);
                else passed++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            step(1'b1, rel_d[j], 1'b1);
            total++;
            if (last_data !== rel_ld[j])
                $display("FAIL hold_release[%0d]: got %h, want %h", j, last_data, rel_ld[j]);
            else passed++;
        end
    endtask

    task automatic test_sparse();
        logic        v;
        logic [15:0] d;
        repeat (3) step(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = (i % 2) == 0;
            d = 16'($urandom);
            step(v, d, 1'b1);
            total++;
            if (m_tvalid !== v || (v && m_tdata !== d))
                $display("FAIL sparse_out[%0d]: got v=%b d=%h, want v=%b d=%h", i, m_tvalid, m_tdata, v, d);
            else passed++;
            total++;
            if (last_data !== mlast || last_valid !== 1'b1)
                $display("FAIL sparse_last[%0d]: got %h/%b, want %h/1", i, last_data, last_valid, mlast);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b1, 16'($urandom), 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tvalid_s !== 1'b0)
            $display("FAIL arst_hs: got v=%b rdy=%b vs=%b, want 0", m_tvalid, s_tready, m_tvalid_s);
        else passed++;
        total++;
        if (xfer_cnt !== 32'd0 || stall_cnt !== 32'd0 || last_valid !== 1'b0)
            $display("FAIL arst_cnt: got x=%0d s=%0d lv=%b, want 0", xfer_cnt, stall_cnt, last_valid);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'd0, 1'b1);
        total++;
        if (m_tvalid !== 1'b0)
            $display("FAIL arst_idle: got v=%b, want 0", m_tvalid);
        else passed++;
        step(1'b1, 16'h0abc, 1'b1);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'h0abc)
            $display("FAIL arst_first: got v=%b d=%h, want v=1 d=0abc", m_tvalid, m_tdata);
        else passed++;
        // Drain so the wrap test starts from an empty stage with zero counts.
        step(1'b0, 16'd0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        logic [1:0] wexp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        step(1'b1, 16'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'(k + 1), 1'b1);
            total++;
            if (xfer_cnt_s !== wexp[k])
                $display("FAIL wrap[%0d]: got %0d, want %0d", k, xfer_cnt_s, wexp[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
            total++;
            if ({m_tvalid, s_tready, xfer_cnt, stall_cnt, last_valid, last_data} !==
                {q.size() > 0, q.size() < 2, mx, ms, mlast_valid, mlast})
                $display("FAIL rand_big[%0d]: got v=%b r=%b x=%0d s=%0d lv=%b ld=%h, want v=%b r=%b x=%0d s=%0d lv=%b ld=%h",
                         i, m_tvalid, s_tready, xfer_cnt, stall_cnt, last_valid, last_data,
                         q.size() > 0, q.size() < 2, mx, ms, mlast_valid, mlast);
            else passed++;
            total++;
            if ({m_tvalid_s, s_tready_s, xfer_cnt_s, stall_cnt_s, last_valid_s, last_data_s} !==
                {q.size() > 0, q.size() < 2, mx[1:0], ms[1:0], mlast_valid, mlast[1:0]})
                $display("FAIL rand_small[%0d]: got v=%b r=%b x=%0d s=%0d lv=%b ld=%0d, want x=%0d s=%0d",
                         i, m_tvalid_s, s_tready_s, xfer_cnt_s, stall_cnt_s, last_valid_s, last_data_s,
                         mx[1:0], ms[1:0]);
            else passed++;
            if (q.size() > 0) begin
                total++;
                if (m_tdata !== q[0] || m_tdata_s !== q[0][1:0])
                    $display("FAIL rand_data[%0d]: got %h/%0d, want %h", i, m_tdata, m_tdata_s, q[0]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_hold();
        test_sparse();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
